// File: rtl/rr_lock_arbiter.sv
// Round-robin arbiter with locked grants: a winner keeps the shared resource
// until it drops its request, the resource signals done, or MaxHold expires.
module rr_lock_arbiter #(
  parameter int NumRequests = 4,
  parameter int MaxHold     = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NumRequests-1:0]         request,
  input  logic                           done,
  output logic [NumRequests-1:0]         grant,
  output logic [$clog2(NumRequests)-1:0] select,
  output logic                           busy,
  output logic                           timeout
);

  localparam int SelW = $clog2(NumRequests);
  localparam int CntW = $clog2(MaxHold + 1);
  localparam logic [CntW-1:0] HoldMax = CntW'(MaxHold);
  localparam logic [SelW-1:0] LastIdx = SelW'(NumRequests - 1);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t                 state, state_n;
  logic [SelW-1:0]        ptr, ptr_n;
  logic [CntW-1:0]        hold_cnt, hold_cnt_n;
  logic [NumRequests-1:0] grant_n;
  logic [SelW-1:0]        select_n;
  logic                   busy_n;
  logic                   timeout_n;

  logic                   found;
  logic [SelW-1:0]        winner;
  logic                   owner_req;
  logic                   hit_max;
  logic                   rel;

  // Hold counter stops at MaxHold rather than wrapping back to zero.
  function automatic logic [CntW-1:0] sat_inc(input logic [CntW-1:0] v);
    return (v == HoldMax) ? v : v + 1'b1;
  endfunction

  // Index increment modulo NumRequests, correct for non-power-of-two counts.
  function automatic logic [SelW-1:0] wrap_inc(input logic [SelW-1:0] v);
    return (v == LastIdx) ? '0 : v + 1'b1;
  endfunction

  always_comb begin
    logic [SelW-1:0] idx;
    found  = 1'b0;
    winner = '0;
    idx    = ptr;
    for (int k = 0; k < NumRequests; k++) begin
      if (!found && request[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
      idx = wrap_inc(idx);
    end
  end

  assign owner_req = request[select];
  assign hit_max   = (hold_cnt == HoldMax);
  assign rel       = done || !owner_req || hit_max;

  always_comb begin
    state_n    = state;
    ptr_n      = ptr;
    hold_cnt_n = hold_cnt;
    grant_n    = grant;
    select_n   = select;
    busy_n     = busy;
    timeout_n  = 1'b0;
    case (state)
      IDLE: begin
        grant_n    = '0;
        select_n   = '0;
        busy_n     = 1'b0;
        hold_cnt_n = '0;
        if (found) begin
          state_n         = HOLD;
          grant_n[winner] = 1'b1;
          select_n        = winner;
          busy_n          = 1'b1;
          hold_cnt_n      = CntW'(1);
        end
      end
      HOLD: begin
        if (rel) begin
          // Returning to IDLE forces one empty cycle before the next grant.
          state_n    = IDLE;
          grant_n    = '0;
          select_n   = '0;
          busy_n     = 1'b0;
          ptr_n      = wrap_inc(select);
          hold_cnt_n = '0;
          timeout_n  = hit_max && !done && owner_req;
        end else begin
          hold_cnt_n = sat_inc(hold_cnt);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= '0;
      hold_cnt <= '0;
      grant    <= '0;
      select   <= '0;
      busy     <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      state    <= state_n;
      ptr      <= ptr_n;
      hold_cnt <= hold_cnt_n;
      grant    <= grant_n;
      select   <= select_n;
      busy     <= busy_n;
      timeout  <= timeout_n;
    end
  end

endmodule

// File: tb/tb_rr_lock_arbiter.sv
// Bench for rr_lock_arbiter: directed scenarios plus a randomized run, all
// checked against a transaction-level owner/pointer model.
module tb_rr_lock_arbiter;

  localparam int N  = 4;
  localparam int MH = 8;
  localparam int SW = $clog2(N);

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  request;
  logic          done;
  logic [N-1:0]  grant;
  logic [SW-1:0] select;
  logic          busy;
  logic          timeout;

  int checks = 0;
  int errors = 0;

  // Reference model: who owns the resource, where the search starts next,
  // how long the owner has held it, and whether a forced release just happened.
  int            m_owner;
  int            m_ptr;
  int            m_cnt;
  bit            m_to;
  logic [N-1:0]  e_grant;
  logic [SW-1:0] e_select;
  logic          e_busy;
  logic          e_to;

  rr_lock_arbiter #(.NumRequests(N), .MaxHold(MH)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .request (request),
    .done    (done),
    .grant   (grant),
    .select  (select),
    .busy    (busy),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit, got running required finished");
    $fatal(1);
  end

  function automatic void model_outputs();
    e_grant  = '0;
    e_select = '0;
    e_busy   = 1'b0;
    if (m_owner >= 0) begin
      e_grant[m_owner] = 1'b1;
      e_select         = SW'(m_owner);
      e_busy           = 1'b1;
    end
    e_to = m_to;
  endfunction

  function automatic void model_reset();
    m_owner = -1;
    m_ptr   = 0;
    m_cnt   = 0;
    m_to    = 0;
    model_outputs();
  endfunction

  function automatic void model_edge(input logic [N-1:0] req, input logic dn);
    int i;
    bit drop, tmo;
    m_to = 0;
    if (m_owner < 0) begin
      for (int k = 0; k < N; k++) begin
        i = (m_ptr + k) % N;
        if (req[i] && m_owner < 0) begin
          m_owner = i;
          m_cnt   = 1;
        end
      end
    end else begin
      drop = !req[m_owner];
      tmo  = (m_cnt == MH);
      if (dn || drop || tmo) begin
        m_to    = tmo && !dn && !drop;
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
        m_cnt   = 0;
      end else begin
        m_cnt++;
      end
    end
    model_outputs();
  endfunction

  task automatic step(input logic [N-1:0] req, input logic dn);
    request = req;
    done    = dn;
    @(posedge clk);
    model_edge(req, dn);
    #1;
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    request = '0;
    done    = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    rst_n   = 1'b1;
    request = '0;
    done    = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({grant, select, busy, timeout} !== '0) begin
      errors++;
      $display("FAIL reset_async got g=%b s=%0d b=%b t=%b required all zero", grant, select, busy, timeout);
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({grant, select, busy, timeout} !== '0) begin
      errors++;
      $display("FAIL reset_held got g=%b s=%0d b=%b t=%b required all zero", grant, select, busy, timeout);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    step('0, 1'b1);
    checks++;
    if ({grant, select, busy, timeout} !== '0) begin
      errors++;
      $display("FAIL idle_done_ignored got g=%b s=%0d b=%b t=%b required all zero", grant, select, busy, timeout);
    end
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    step(4'b0100, 1'b0);
    step(4'b0100, 1'b0);
    checks++;
    if (grant !== 4'b0100 || select !== 2'd2 || busy !== 1'b1) begin
      errors++;
      $display("FAIL midrst_pre got g=%b s=%0d b=%b required g=0100 s=2 b=1", grant, select, busy);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (grant !== '0 || busy !== 1'b0 || select !== '0) begin
      errors++;
      $display("FAIL midrst_async got g=%b s=%0d b=%b required g=0000 s=0 b=0", grant, select, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    step(4'b1111, 1'b0);
    checks++;
    if (grant !== 4'b0001 || select !== 2'd0) begin
      errors++;
      $display("FAIL midrst_ptr got g=%b s=%0d required g=0001 s=0", grant, select);
    end
    step(4'b1111, 1'b1);
    step('0, 1'b0);
  endtask

  task automatic test_rotation();
    logic [N-1:0] exp_g;
    do_reset();
    for (int g = 0; g < 5; g++) begin
      exp_g = '0;
      exp_g[g % N] = 1'b1;
      step(4'b1111, 1'b0);
      checks++;
      if (grant !== exp_g || select !== SW'(g % N)) begin
        errors++;
        $display("FAIL rotation_grant%0d got g=%b s=%0d required g=%b s=%0d", g, grant, select, exp_g, g % N);
      end
      step(4'b1111, 1'b0);
      step(4'b1111, 1'b1);
      checks++;
      if ({grant, select, busy, timeout} !== {e_grant, e_select, e_busy, e_to} || grant !== '0) begin
        errors++;
        $display("FAIL rotation_bubble%0d got g=%b s=%0d b=%b t=%b required g=0000 s=0 b=0 t=0", g, grant, select, busy, timeout);
      end
    end
  endtask

  task automatic test_wrap_search();
    do_reset();
    step(4'b1000, 1'b0);
    step(4'b1000, 1'b1);
    step(4'b0100, 1'b0);
    checks++;
    if (grant !== 4'b0100 || select !== 2'd2) begin
      errors++;
      $display("FAIL wrap_first got g=%b s=%0d required g=0100 s=2", grant, select);
    end
    step(4'b0100, 1'b1);
    step(4'b0011, 1'b0);
    checks++;
    if (grant !== 4'b0001 || select !== 2'd0) begin
      errors++;
      $display("FAIL wrap_second got g=%b s=%0d required g=0001 s=0", grant, select);
    end
    step(4'b0011, 1'b1);
    step('0, 1'b0);
  endtask

  task automatic test_release_by_drop();
    do_reset();
    step(4'b0010, 1'b0);
    checks++;
    if (grant !== 4'b0010 || select !== 2'd1) begin
      errors++;
      $display("FAIL drop_grant got g=%b s=%0d required g=0010 s=1", grant, select);
    end
    step(4'b0010, 1'b0);
    step(4'b0010, 1'b0);
    step(4'b0000, 1'b0);
    checks++;
    if (grant !== '0 || busy !== 1'b0 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL drop_release got g=%b b=%b t=%b required g=0000 b=0 t=0", grant, busy, timeout);
    end
    step(4'b1111, 1'b0);
    checks++;
    if (grant !== 4'b0100 || select !== 2'd2) begin
      errors++;
      $display("FAIL drop_ptr got g=%b s=%0d required g=0100 s=2", grant, select);
    end
    step(4'b1111, 1'b1);
    step('0, 1'b0);
  endtask

  task automatic test_timeout();
    int held;
    do_reset();
    step(4'b0010, 1'b0);
    held = (grant === 4'b0010) ? 1 : 0;
    for (int c = 0; c < 20; c++) begin
      step(4'b0010, 1'b0);
      checks++;
      if ({grant, select, busy, timeout} !== {e_grant, e_select, e_busy, e_to}) begin
        errors++;
        $display("FAIL timeout_cycle%0d got g=%b s=%0d b=%b t=%b required g=%b s=%0d b=%b t=%b",
                 c, grant, select, busy, timeout, e_grant, e_select, e_busy, e_to);
      end
      if (grant === 4'b0010) held++;
      else break;
    end
    checks++;
    if (held != MH) begin
      errors++;
      $display("FAIL timeout_hold_len got %0d cycles required %0d", held, MH);
    end
    checks++;
    if (grant !== '0 || timeout !== 1'b1) begin
      errors++;
      $display("FAIL timeout_pulse got g=%b t=%b required g=0000 t=1", grant, timeout);
    end
    step(4'b0010, 1'b0);
    checks++;
    if (grant !== 4'b0010 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL timeout_regrant got g=%b t=%b required g=0010 t=0", grant, timeout);
    end
    step(4'b0010, 1'b1);
    step('0, 1'b0);
  endtask

  task automatic test_coincident();
    logic [N-1:0] r;
    do_reset();
    step(4'b0001, 1'b0);
    for (int c = 1; c < MH; c++) begin
      r = N'($urandom_range(0, (1 << N) - 1)) | 4'b0001;
      step(r, 1'b0);
      checks++;
      if (grant !== 4'b0001 || select !== 2'd0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL coinc_locked%0d got g=%b s=%0d b=%b required g=0001 s=0 b=1", c, grant, select, busy);
      end
    end
    step(4'b1111, 1'b1);
    checks++;
    if (grant !== '0 || busy !== 1'b0 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL coinc_release got g=%b b=%b t=%b required g=0000 b=0 t=0", grant, busy, timeout);
    end
    step(4'b1111, 1'b0);
    checks++;
    if (grant !== 4'b0010 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL coinc_next got g=%b t=%b required g=0010 t=0", grant, timeout);
    end
    step(4'b1111, 1'b1);
    step('0, 1'b0);
  endtask

  task automatic test_random();
    logic [N-1:0] r;
    logic         d;
    do_reset();
    r = '0;
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 3) == 0) r = N'($urandom_range(0, (1 << N) - 1));
      d = ($urandom_range(0, 5) == 0);
      step(r, d);
      checks++;
      if ({grant, select, busy, timeout} !== {e_grant, e_select, e_busy, e_to}) begin
        errors++;
        $display("FAIL random_cycle%0d req=%b done=%b got g=%b s=%0d b=%b t=%b required g=%b s=%0d b=%b t=%b",
                 c, r, d, grant, select, busy, timeout, e_grant, e_select, e_busy, e_to);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_reset_mid_grant();
    test_rotation();
    test_wrap_search();
    test_release_by_drop();
    test_timeout();
    test_coincident();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
